pwm_capture: RTL and testbench

Receive-side counterpart of the PWM LED generator: samples an incoming PWM waveform, measures its period and high time in `clk` cycles, and decodes the high time back into the 3-bit duty level (0-7) that produced it. It sits on a board input or a loopback of the generator output and reports each completed period with a one-cycle `valid` strobe, plus lock, period-error and stuck-line status for self-test.

---
 rtl/pwm_capture.sv | 148 ++++++++++++++
 tb/tb_pwm_capture.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM waveform,
// decodes the high time into a 3-bit duty level and reports lock, period
// error and stuck-line status. One-cycle valid per completed period.

// Single threshold comparator: high time at or above THR.
module pwm_capture_thr #(
  parameter int unsigned THR = 0
) (
  input  logic [15:0] h,
  output logic        ge
);
  // Widen to 32 bits so thresholds above 0xFFFF simply never match.
  assign ge = ({16'd0, h} >= THR);
endmodule

module pwm_capture #(
  parameter int unsigned PERIOD  = 50002,
  parameter int unsigned STEP    = 5000,
  parameter int unsigned TOL     = 64,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [2:0]  level,
  output logic        valid,
  output logic [15:0] high_count,
  output logic [15:0] period_count,
  output logic        locked,
  output logic        period_err,
  output logic        stuck,
  output logic        stuck_high
);

  localparam int unsigned NUM_THR = 7;
  localparam logic [31:0] P_LO    = 32'(PERIOD - TOL);
  localparam logic [31:0] P_HI    = 32'(PERIOD + TOL);
  localparam logic [15:0] TMO     = 16'(TIMEOUT);
  localparam logic [15:0] SAT     = 16'hFFFF;

  typedef enum logic {IDLE, MEASURE} state_t;

  // One completed measurement, as it will be published.
  typedef struct packed {
    logic [2:0]  level;
    logic [15:0] high;
    logic [15:0] period;
    logic        err;
  } meas_t;

  state_t               state;
  logic [2:0]           sync_pipe;   // [0]=s1, [1]=s2, [2]=s3
  logic                 s2, s3, rise, tmo;
  logic [15:0]          pcnt, hcnt;
  logic [NUM_THR-1:0]   thr_ge;
  logic [2:0]           lvl_dec;
  logic                 p_bad;
  meas_t                meas;

  assign s2   = sync_pipe[1];
  assign s3   = sync_pipe[2];
  assign rise = s2 & ~s3;
  // A rise in the same cycle overrides the timeout.
  assign tmo  = (pcnt == TMO) & ~rise;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], pwm_in};
  end

  // Period and high-time counters; restart on rise, saturate at 0xFFFF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      pcnt <= 16'd1;
      hcnt <= 16'd1;
    end else begin
      if (pcnt != SAT)       pcnt <= pcnt + 16'd1;
      if (s2 && hcnt != SAT) hcnt <= hcnt + 16'd1;
    end
  end

  // Thermometer of level thresholds STEP*j + STEP/2, j = 1..7.
  for (genvar j = 1; j <= NUM_THR; j++) begin : g_thr
    pwm_capture_thr #(.THR(STEP * j + STEP / 2)) u_thr (
      .h  (hcnt),
      .ge (thr_ge[j-1])
    );
  end

  // Level = number of thresholds reached.
  always_comb begin
    lvl_dec = 3'd0;
    for (int j = 0; j < NUM_THR; j++) lvl_dec = lvl_dec + {2'b00, thr_ge[j]};
  end

  assign p_bad = ({16'd0, pcnt} < P_LO) | ({16'd0, pcnt} > P_HI);
  assign meas  = '{level: lvl_dec, high: hcnt, period: pcnt, err: p_bad};

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      level        <= '0;
      valid        <= 1'b0;
      high_count   <= '0;
      period_count <= '0;
      locked       <= 1'b0;
      period_err   <= 1'b0;
      stuck        <= 1'b0;
      stuck_high   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
          end else if (tmo) begin
            locked <= 1'b0;
            stuck  <= 1'b1;
            if (!stuck) stuck_high <= s2;
          end
        end
        MEASURE: begin
          if (rise) begin
            level        <= meas.level;
            high_count   <= meas.high;
            period_count <= meas.period;
            period_err   <= meas.err;
            locked       <= ~meas.err;
            stuck        <= 1'b0;
            valid        <= 1'b1;
          end else if (tmo) begin
            locked <= 1'b0;
            stuck  <= 1'b1;
            if (!stuck) stuck_high <= s2;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down parameters.
module tb_pwm_capture;

  localparam int PERIOD  = 502;
  localparam int STEP    = 50;
  localparam int TOL     = 4;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [2:0]  level;
  logic        valid;
  logic [15:0] high_count, period_count;
  logic        locked, period_err, stuck, stuck_high;

  pwm_capture #(.PERIOD(PERIOD), .STEP(STEP), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .level        (level),
    .valid        (valid),
    .high_count   (high_count),
    .period_count (period_count),
    .locked       (locked),
    .period_err   (period_err),
    .stuck        (stuck),
    .stuck_high   (stuck_high)
  );

  always #5 clk = ~clk;

  typedef struct {int lvl; int h; int p; int err;} exp_t;

  exp_t exp_q[$];
  exp_t pend;
  exp_t mon_e;
  int   n_chk = 0, n_err = 0, n_valid = 0;
  int   cyc = 0, rise_cyc = 0;
  bit   tb_idle = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A rise completes the pending period unless the DUT is idle.
  task automatic mark_rise();
    rise_cyc = cyc;
    if (!tb_idle) exp_q.push_back(pend);
    tb_idle = 1'b0;
  endtask

  // One PWM period: high h cycles, then low p-h cycles. Starts/ends 1 unit after posedge.
  task automatic send(input int h, input int p, input int lvl, input int err);
    pwm_in = 1'b1;
    mark_rise();
    pend = '{lvl, h, p, err};
    repeat (h) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (p - h) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"},      level, 0);
    chk({tag, "_valid"},      valid, 0);
    chk({tag, "_high"},       high_count, 0);
    chk({tag, "_period"},     period_count, 0);
    chk({tag, "_locked"},     locked, 0);
    chk({tag, "_perr"},       period_err, 0);
    chk({tag, "_stuck"},      stuck, 0);
    chk({tag, "_stuck_high"}, stuck_high, 0);
  endtask

  // Scoreboard: every valid must match the next expected measurement.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("level",        level, mon_e.lvl);
        chk("high_count",   high_count, mon_e.h);
        chk("period_count", period_count, mon_e.p);
        chk("period_err",   period_err, mon_e.err);
        chk("locked",       locked, (mon_e.err == 0) ? 1 : 0);
        chk("stuck_clr",    stuck, 0);
        chk("latency",      cyc - rise_cyc, 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_state("rst");
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Lock-in at load 3, then sweep all loads: high = 50*(k+1)+1.
    send(201, 502, 3, 0);
    for (int k = 0; k < 8; k++) send(STEP * (k + 1) + 1, PERIOD, k, 0);

    // Threshold edges: T1 = 75, T7 = 375.
    send(74,  502, 0, 0);
    send(75,  502, 1, 0);
    send(374, 502, 6, 0);
    send(375, 502, 7, 0);

    // Period tolerance window 498..506.
    send(201, 510, 3, 1);
    send(201, 502, 3, 0);
    send(201, 506, 3, 0);
    send(201, 507, 3, 1);
    send(201, 498, 3, 0);
    send(201, 497, 3, 1);
    send(201, 502, 3, 0);

    // Rise then hold high: stuck appears exactly TIMEOUT cycles after the valid.
    pwm_in = 1'b1;
    mark_rise();
    repeat (TIMEOUT + 2) @(posedge clk);
    @(negedge clk);
    chk("pre_tmo_stuck",  stuck, 0);
    chk("pre_tmo_locked", locked, 1);
    @(negedge clk);
    chk("tmo_stuck",      stuck, 1);
    chk("tmo_stuck_high", stuck_high, 1);
    chk("tmo_locked",     locked, 0);
    chk("tmo_level_hold", level, 3);
    chk("tmo_period_hold", period_count, 502);
    chk("tmo_high_hold",  high_count, 201);
    chk("tmo_perr_hold",  period_err, 0);
    tb_idle = 1'b1;
    @(posedge clk); #1 pwm_in = 1'b0;
    repeat (50) @(posedge clk); #1;

    // Resume: first rise silent, second reports and clears stuck.
    send(201, 502, 3, 0);
    chk("resume_stuck_held", stuck, 1);
    send(101, 502, 1, 0);

    // Reset in the middle of a high phase.
    pwm_in = 1'b1;
    mark_rise();
    repeat (20) @(posedge clk);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_level",  level, 1);
    #3 reset = 1'b0;
    #1 chk_reset_state("midrst");
    pwm_in  = 1'b0;
    tb_idle = 1'b1;
    repeat (5) @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk); #1;
    send(201, 502, 3, 0);
    chk("post_rst_no_valid", n_valid, 22);
    send(151, 502, 2, 0);

    repeat (10) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("valid_count", n_valid, 23);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
